// File: rtl/countdown_ctrl.sv
// Button-driven sequencer for the down-counter datapath.
// Owns the tick prescaler and raises done/done_pulse on expiry.
module countdown_ctrl #(
  parameter int N        = 6,
  parameter int TICK_DIV = 15_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_btn,
  input  logic         pause_btn,
  input  logic [N-1:0] a,
  input  logic [N-1:0] z,
  output logic         cnt_load,
  output logic         cnt_dec,
  output logic         done,
  output logic         done_pulse,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [31:0] TOP = 32'(TICK_DIV - 1);

  state_e      state_q, state_d;
  logic [31:0] pre_q, pre_d;
  logic        dp_q, dp_d;
  // [0] first sync flop, [1] second sync flop, [2] previous value
  logic [2:0]  st_q, pa_q;

  logic start_p, pause_p;
  logic at_top, z_zero;
  logic unused_a;

  assign unused_a = ^a;

  assign start_p = st_q[2] & ~st_q[1];
  assign pause_p = pa_q[2] & ~pa_q[1];
  assign at_top  = (pre_q == TOP);
  assign z_zero  = (z == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      dp_q    <= 1'b0;
      st_q    <= 3'b111;
      pa_q    <= 3'b111;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      dp_q    <= dp_d;
      st_q    <= {st_q[1:0], start_btn};
      pa_q    <= {pa_q[1:0], pause_btn};
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_dec = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_p) state_d = LOAD;
      end
      LOAD: begin
        pre_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // A press freezes the prescaler so a resume picks up mid-tick
        if (start_p) begin
          state_d = LOAD;
        end else if (pause_p) begin
          state_d = PAUSE;
        end else begin
          if (z_zero) state_d = DONE;
          pre_d   = at_top ? '0 : pre_q + 32'd1;
          cnt_dec = at_top & ~z_zero;
        end
      end
      PAUSE: begin
        if (start_p)      state_d = LOAD;
        else if (pause_p) state_d = RUN;
      end
      DONE: begin
        if (start_p)      state_d = LOAD;
        else if (pause_p) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    dp_d = (state_d == DONE) && (state_q != DONE);
  end

  assign cnt_load   = (state_q == LOAD);
  assign done       = (state_q == DONE);
  assign done_pulse = dp_q;
  assign state      = state_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: behavioural datapath, reference model,
// directed scenarios and a randomized button soak.
module tb_countdown_ctrl;

  localparam int N  = 6;
  localparam int TD = 4;

  localparam int S_IDLE  = 0;
  localparam int S_LOAD  = 1;
  localparam int S_RUN   = 2;
  localparam int S_PAUSE = 3;
  localparam int S_DONE  = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_btn = 1'b1;
  logic         pause_btn = 1'b1;
  logic [N-1:0] a = '0;
  logic [N-1:0] z_tb;
  logic         cnt_load, cnt_dec, done, done_pulse;
  logic [2:0]   state;

  int npass = 0;
  int ntot  = 0;

  countdown_ctrl #(.N(N), .TICK_DIV(TD)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .start_btn (start_btn),
    .pause_btn (pause_btn),
    .a         (a),
    .z         (z_tb),
    .cnt_load  (cnt_load),
    .cnt_dec   (cnt_dec),
    .done      (done),
    .done_pulse(done_pulse),
    .state     (state)
  );

  always #5 clk = ~clk;

  // behavioural down-counter datapath
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        z_tb <= '0;
    else if (cnt_load) z_tb <= a;
    else if (cnt_dec)  z_tb <= z_tb - 1'b1;
  end

  // reference model: mode, RUN-cycle count since load, expected z
  int         m_st, m_nx, m_run;
  logic [N-1:0] m_z;
  logic       m_dp;
  logic [2:0] m_sh, m_ph;
  logic       m_start, m_pause, e_load, e_dec;

  always_comb begin
    m_start = m_sh[2] && !m_sh[1];
    m_pause = m_ph[2] && !m_ph[1];
    e_load  = (m_st == S_LOAD);
    e_dec   = (m_st == S_RUN) && (m_run % TD == TD - 1) &&
              (m_z != 0) && !m_start && !m_pause;
    m_nx = m_st;
    if (m_st == S_LOAD) m_nx = S_RUN;
    else if (m_start) m_nx = S_LOAD;
    else if (m_st == S_RUN && m_pause) m_nx = S_PAUSE;
    else if (m_st == S_RUN && m_z == 0) m_nx = S_DONE;
    else if (m_st == S_PAUSE && m_pause) m_nx = S_RUN;
    else if (m_st == S_DONE && m_pause) m_nx = S_IDLE;
    if (m_st == S_IDLE && !m_start) m_nx = S_IDLE;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st  <= S_IDLE;
      m_run <= 0;
      m_z   <= '0;
      m_dp  <= 1'b0;
      m_sh  <= 3'b111;
      m_ph  <= 3'b111;
    end else begin
      m_sh <= {m_sh[1:0], start_btn};
      m_ph <= {m_ph[1:0], pause_btn};
      m_st <= m_nx;
      m_dp <= (m_nx == S_DONE) && (m_st != S_DONE);
      if (e_load)     m_z <= a;
      else if (e_dec) m_z <= m_z - 1'b1;
      if (m_st == S_LOAD) m_run <= 0;
      else if (m_st == S_RUN && !m_start && !m_pause) m_run <= m_run + 1;
    end
  end

  logic [12:0] obs_v, exp_v;
  assign obs_v = {state, cnt_load, cnt_dec, done, done_pulse, z_tb};
  assign exp_v = {3'(m_st), e_load, e_dec, (m_st == S_DONE), m_dp, m_z};

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start_btn = 1'b1;
    pause_btn = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    repeat (3) step();
    ntot++;
    if ({state, cnt_load, cnt_dec, done, done_pulse} !== 7'd0)
      $display("FAIL reset_outputs: got %b want 0000000",
               {state, cnt_load, cnt_dec, done, done_pulse});
    else npass++;
    start_btn = 1'b1;
    pause_btn = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      ntot++;
      if (obs_v !== exp_v)
        $display("FAIL reset_model: got %h want %h", obs_v, exp_v);
      else npass++;
    end
    ntot++;
    if (state !== 3'd0) $display("FAIL reset_idle: got %0d want 0", state);
    else npass++;
  endtask

  task automatic test_countdown();
    int loads = 0;
    int decs = 0;
    int dps = 0;
    do_reset();
    a = 6'd3;
    start_btn = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 3) start_btn = 1'b1;
      ntot++;
      if (obs_v !== exp_v)
        $display("FAIL count_model: cyc %0d got %h want %h", i, obs_v, exp_v);
      else npass++;
      loads += int'(cnt_load);
      decs  += int'(cnt_dec);
      dps   += int'(done_pulse);
    end
    ntot++;
    if (loads != 1) $display("FAIL count_loads: got %0d want 1", loads);
    else npass++;
    ntot++;
    if (decs != 3) $display("FAIL count_decs: got %0d want 3", decs);
    else npass++;
    ntot++;
    if (dps != 1) $display("FAIL count_done_pulse: got %0d want 1", dps);
    else npass++;
    ntot++;
    if ({done, state, z_tb} !== {1'b1, 3'd4, 6'd0})
      $display("FAIL count_end: got done=%b st=%0d z=%0d want 1/4/0",
               done, state, z_tb);
    else npass++;
  endtask

  task automatic test_pause();
    int k = 0;
    int decs = 0;
    int bad = 0;
    int first = -1;
    do_reset();
    a = 6'd20;
    start_btn = 1'b0;
    while (k < 40 && m_st != S_RUN) begin
      step();
      ntot++;
      if (obs_v !== exp_v)
        $display("FAIL pause_model: got %h want %h", obs_v, exp_v);
      else npass++;
      k++;
    end
    ntot++;
    if (k >= 40) $display("FAIL pause_wait_run: got timeout want RUN");
    else npass++;
    start_btn = 1'b1;
    pause_btn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      ntot++;
      if (obs_v !== exp_v)
        $display("FAIL pause_model: got %h want %h", obs_v, exp_v);
      else npass++;
    end
    pause_btn = 1'b1;
    ntot++;
    if (state !== 3'd3) $display("FAIL pause_enter: got %0d want 3", state);
    else npass++;
    for (int i = 0; i < 20; i++) begin
      step();
      decs += int'(cnt_dec);
      if (state !== 3'd3) bad++;
    end
    ntot++;
    if (decs != 0) $display("FAIL pause_no_dec: got %0d want 0", decs);
    else npass++;
    ntot++;
    if (bad != 0) $display("FAIL pause_hold: got %0d bad want 0", bad);
    else npass++;
    pause_btn = 1'b0;
    repeat (3) step();
    pause_btn = 1'b1;
    ntot++;
    if (state !== 3'd2) $display("FAIL pause_resume: got %0d want 2", state);
    else npass++;
    for (int j = 0; j < 10; j++) begin
      if (cnt_dec && first < 0) first = j;
      ntot++;
      if (obs_v !== exp_v)
        $display("FAIL resume_model: got %h want %h", obs_v, exp_v);
      else npass++;
      step();
    end
    ntot++;
    if (first != 1) $display("FAIL resume_dec_cycle: got %0d want 1", first);
    else npass++;
  endtask

  task automatic test_zero_preset();
    int seq[6] = '{0, 0, 1, 2, 4, 4};
    int decs = 0;
    do_reset();
    a = 6'd0;
    start_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      decs += int'(cnt_dec);
      if (i < 6) begin
        ntot++;
        if (int'(state) != seq[i])
          $display("FAIL zero_seq: cyc %0d got %0d want %0d", i, state, seq[i]);
        else npass++;
      end
    end
    start_btn = 1'b1;
    ntot++;
    if (decs != 0) $display("FAIL zero_no_dec: got %0d want 0", decs);
    else npass++;
  endtask

  task automatic test_both_press();
    int k = 0;
    do_reset();
    a = 6'd30;
    start_btn = 1'b0;
    while (k < 40 && m_st != S_RUN) begin
      step();
      k++;
    end
    ntot++;
    if (k >= 40) $display("FAIL both_wait_run: got timeout want RUN");
    else npass++;
    start_btn = 1'b1;
    step();
    pause_btn = 1'b0;
    repeat (3) step();
    pause_btn = 1'b1;
    ntot++;
    if (state !== 3'd3) $display("FAIL both_pause: got %0d want 3", state);
    else npass++;
    step();
    step();
    a = 6'd12;
    start_btn = 1'b0;
    pause_btn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      ntot++;
      if (obs_v !== exp_v)
        $display("FAIL both_model: got %h want %h", obs_v, exp_v);
      else npass++;
    end
    ntot++;
    if ({state, cnt_load} !== {3'd1, 1'b1})
      $display("FAIL both_load: got st=%0d ld=%b want 1/1", state, cnt_load);
    else npass++;
    step();
    start_btn = 1'b1;
    pause_btn = 1'b1;
    ntot++;
    if ({state, z_tb} !== {3'd2, 6'd12})
      $display("FAIL both_reload: got st=%0d z=%0d want 2/12", state, z_tb);
    else npass++;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    int loads = 0;
    do_reset();
    a = 6'd10;
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    while (k < 60 && !(m_st == S_RUN && m_z == 6'd7)) begin
      step();
      k++;
    end
    ntot++;
    if (k >= 60 || z_tb !== 6'd7)
      $display("FAIL mid_wait: got k=%0d z=%0d want z=7", k, z_tb);
    else npass++;
    rst_n = 1'b0;
    #1;
    ntot++;
    if ({state, cnt_load, cnt_dec, done, done_pulse} !== 7'd0)
      $display("FAIL mid_abort: got %b want 0000000",
               {state, cnt_load, cnt_dec, done, done_pulse});
    else npass++;
    step();
    ntot++;
    if ({state, cnt_load, cnt_dec} !== 5'd0)
      $display("FAIL mid_abort_hold: got %b want 00000",
               {state, cnt_load, cnt_dec});
    else npass++;
    rst_n = 1'b1;
    start_btn = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      loads += int'(cnt_load);
      ntot++;
      if (obs_v !== exp_v)
        $display("FAIL hold_model: got %h want %h", obs_v, exp_v);
      else npass++;
    end
    start_btn = 1'b1;
    ntot++;
    if (loads != 1) $display("FAIL hold_one_load: got %0d want 1", loads);
    else npass++;
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 11) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 9) == 0)  pause_btn = ~pause_btn;
      if ($urandom_range(0, 3) == 0)  a = 6'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 299) != 0);
      step();
      if (cnt_load && cnt_dec) errs++;
      ntot++;
      if (obs_v !== exp_v)
        $display("FAIL rand_model: cyc %0d got %h want %h", i, obs_v, exp_v);
      else npass++;
    end
    rst_n = 1'b1;
    start_btn = 1'b1;
    pause_btn = 1'b1;
    ntot++;
    if (errs != 0) $display("FAIL rand_exclusive: got %0d want 0", errs);
    else npass++;
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_zero_preset();
    test_both_press();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
